// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared load/store definitions: data word type, RV64I funct3 encodings,
// controller state encoding and the request legality check.
package lsu_mem_ctrl_pkg;

  typedef logic [63:0] dw_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef logic [1:0] lsu_state_e;
  localparam lsu_state_e ST_IDLE = 2'd0;
  localparam lsu_state_e ST_REQ  = 2'd1;
  localparam lsu_state_e ST_WAIT = 2'd2;
  localparam lsu_state_e ST_DONE = 2'd3;

  // True when the access can never reach memory: bad encoding or misaligned.
  function automatic logic lsu_bad(input logic we, input logic [2:0] funct3,
                                   input logic [2:0] off);
    logic illegal;
    logic misaligned;
    illegal = (funct3 == 3'b111) || (we && funct3[2]);
    case (funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane alignment: store strobes/data placement and load extract/extend.
module lsu_mem_ctrl_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [2:0] off,
  input  dw_t        st_data,
  input  dw_t        rd_data,
  output logic [7:0] wstrb,
  output dw_t        wdata,
  output dw_t        ld_data
);

  logic [7:0] mask;
  logic [5:0] sh_amt;
  dw_t        sh;

  always_comb begin
    sh_amt = {off, 3'b000};
    case (funct3[1:0])
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    wstrb = mask << off;
    wdata = st_data << sh_amt;
    sh    = rd_data >> sh_amt;
    case (funct3)
      F3_B:    ld_data = {{56{sh[7]}}, sh[7:0]};
      F3_H:    ld_data = {{48{sh[15]}}, sh[15:0]};
      F3_W:    ld_data = {{32{sh[31]}}, sh[31:0]};
      F3_D:    ld_data = sh;
      F3_BU:   ld_data = {56'd0, sh[7:0]};
      F3_HU:   ld_data = {48'd0, sh[15:0]};
      F3_WU:   ld_data = {32'd0, sh[31:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller: one outstanding transaction on a
// valid/ready data-memory port, with pipeline stall and load writeback data.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   ld_data_M,
  output logic              ld_valid_M,
  output logic              lsu_err
);

  lsu_state_e state_q, state_d;
  logic       accept_c, err_c, bad_c;
  logic [2:0] lat_f3, lat_off;
  logic [2:0] f3_sel, off_sel;
  logic [7:0] al_wstrb;
  dw_t        al_wdata, al_ld;

  assign bad_c = lsu_bad(req_we, req_funct3, req_addr[2:0]);

  // Incoming request drives the aligner in IDLE; the latched one afterwards.
  assign f3_sel  = (state_q == ST_IDLE) ? req_funct3    : lat_f3;
  assign off_sel = (state_q == ST_IDLE) ? req_addr[2:0] : lat_off;

  lsu_mem_ctrl_align u_align (
    .funct3  (f3_sel),
    .off     (off_sel),
    .st_data (req_wdata),
    .rd_data (mem_rdata),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, accept/error decode and the combinational stall.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    accept_c = 1'b0;
    err_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (bad_c) begin
            err_c = 1'b1;
          end else begin
            accept_c = 1'b1;
            stall    = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, memory port registers and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wstrb     <= '0;
      mem_wdata     <= '0;
      ld_data_M     <= '0;
      ld_valid_M    <= 1'b0;
      lsu_err       <= 1'b0;
      lat_f3        <= '0;
      lat_off       <= '0;
    end else begin
      lsu_err    <= err_c;
      ld_valid_M <= 1'b0;
      if (accept_c) begin
        mem_req_valid <= 1'b1;
        mem_we        <= req_we;
        mem_addr      <= {req_addr[ADDR_W-1:3], 3'b000};
        mem_wstrb     <= req_we ? al_wstrb : 8'h00;
        mem_wdata     <= req_we ? al_wdata : '0;
        lat_f3        <= req_funct3;
        lat_off       <= req_addr[2:0];
      end else if (state_q == ST_REQ && mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
      if (state_q == ST_WAIT && mem_rsp_valid && !mem_we) begin
        ld_data_M  <= al_ld;
        ld_valid_M <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: driver pushes expectations from a
// behavioural model, a negedge monitor pops and compares.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        stall;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, ld_data_M;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid, ld_valid_M, lsu_err;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .ld_data_M(ld_data_M), .ld_valid_M(ld_valid_M),
    .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } mem_exp_t;

  mem_exp_t    exp_mem_q[$];
  logic [63:0] exp_ld_q[$];
  int          exp_stall_q[$];
  int          checks = 0, failures = 0;
  int          exp_err = 0, seen_err = 0;
  int          run = 0;
  logic [63:0] last_ld = '0;
  mem_exp_t    mon_e;
  logic [63:0] mon_x;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, legality, and lane arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_bad(input logic we, input logic [2:0] f3, input logic [63:0] addr);
    if (f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (int'(addr[2:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int          n, off;
    logic [63:0] v, mask;
    n    = nbytes(f3);
    off  = int'(addr[2:0]);
    v    = rdata >> (8 * off);
    mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v    = v & mask;
    if (f3 < 3'd4 && n < 8 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Garbage on the request bus while the controller is busy.
  task automatic junk();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid     = 1'b0;
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = 1'($urandom);
      mem_rdata     = {$urandom, $urandom};
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int rdy, input int rsp);
    bit       bad;
    mem_exp_t e;
    int       off;
    bad = is_bad(we, f3, addr);
    off = int'(addr[2:0]);
    if (bad) begin
      exp_err++;
    end else begin
      e.we    = we;
      e.addr  = addr & ~64'd7;
      e.strb  = 8'(((1 << nbytes(f3)) - 1) << off);
      e.wdata = wd << (8 * off);
      exp_mem_q.push_back(e);
      if (!we) exp_ld_q.push_back(ld_model(f3, addr, rd));
      exp_stall_q.push_back(3 + rdy + rsp);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    mem_rsp_valid = 1'b0;
    mem_req_ready = (rdy == 0);
    #1;
    if (bad) chk("stall_on_bad_req", 64'(stall), 64'd0);
    step();
    req_valid = 1'b0;
    if (bad) begin
      mem_req_ready = 1'b0;
      return;
    end
    for (int i = 0; i < rdy; i++) begin
      mem_req_ready = 1'b0;
      junk();
      step();
    end
    mem_req_ready = 1'b1;
    junk();
    chk("mem_req_valid_before_handshake", 64'(mem_req_valid), 64'd1);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp; i++) begin
      mem_rsp_valid = 1'b0;
      junk();
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = rd;
    junk();
    step();
    mem_rsp_valid = 1'b0;
    req_valid     = 1'b0;
    mem_rdata     = {$urandom, $urandom};
    step();
  endtask

  // Load reaches WAIT, reset hits, then a stale response arrives.
  task automatic reset_in_wait();
    mem_exp_t e;
    e.we = 1'b0; e.addr = 64'h6000; e.strb = '0; e.wdata = '0;
    exp_mem_q.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h6000;
    mem_req_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'hDEAD_BEEF_CAFE_F00D;
      step();
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_ld_valid", 64'(ld_valid_M), 64'd0);
      chk("rst_ld_data", ld_data_M, 64'd0);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    end
    mem_rsp_valid = 1'b0;
  endtask

  // Monitor: memory requests, load results, data hold, stall run lengths.
  always @(negedge clk) begin
    if (rst) begin
      run     = 0;
      last_ld = '0;
    end else begin
      if (mem_req_valid) begin
        if (exp_mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_req_unexpected: got request addr %h, expected none", mem_addr);
        end else begin
          mon_e = exp_mem_q[0];
          chk("mem_we", 64'(mem_we), 64'(mon_e.we));
          chk("mem_addr", mem_addr, mon_e.addr);
          if (mon_e.we) begin
            chk("mem_wstrb", 64'(mem_wstrb), 64'(mon_e.strb));
            chk("mem_wdata", mem_wdata, mon_e.wdata);
          end
          if (mem_req_ready) void'(exp_mem_q.pop_front());
        end
      end
      if (ld_valid_M) begin
        if (exp_ld_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ld_valid_unexpected: got pulse data %h, expected none", ld_data_M);
        end else begin
          mon_x = exp_ld_q.pop_front();
          chk("ld_data_M", ld_data_M, mon_x);
          last_ld = mon_x;
        end
      end else begin
        chk("ld_data_hold", ld_data_M, last_ld);
      end
      if (lsu_err) seen_err++;
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (exp_stall_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL stall_unexpected: got run of %0d, expected none", run);
        end else begin
          chk("stall_cycles", 64'(run), 64'(exp_stall_q.pop_front()));
        end
        run = 0;
      end
    end
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = '1;
    repeat (3) step();
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    chk("reset_ld_data", ld_data_M, 64'd0);
    chk("reset_ld_valid", 64'(ld_valid_M), 64'd0);
    chk("reset_lsu_err", 64'(lsu_err), 64'd0);
    mem_rsp_valid = 1'b0;
    rst = 1'b0;
    idle_gap(2);

    run_txn(1'b0, 3'b010, 64'h1004, 64'h0, 64'h8000_0001_1234_5678, 0, 0);
    run_txn(1'b0, 3'b100, 64'h2007, 64'h0, 64'hA512_3456_789A_BCDE, 0, 0);
    run_txn(1'b0, 3'b000, 64'h2007, 64'h0, 64'hA512_3456_789A_BCDE, 0, 0);
    run_txn(1'b1, 3'b001, 64'h3002, 64'h1122_3344_5566_BEEF, 64'h0, 0, 0);
    run_txn(1'b0, 3'b011, 64'h4004, 64'h0, 64'h0, 0, 0);
    run_txn(1'b0, 3'b111, 64'h4000, 64'h0, 64'h0, 0, 0);
    run_txn(1'b1, 3'b100, 64'h4000, 64'h0, 64'h0, 0, 0);
    run_txn(1'b0, 3'b011, 64'h5000, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 2);
    run_txn(1'b1, 3'b011, 64'h5008, 64'hFEDC_BA98_7654_3210, 64'h0, 3, 2);
    idle_gap(2);
    reset_in_wait();
    idle_gap(2);

    for (int t = 0; t < 200; t++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = {$urandom, $urandom};
      if ($urandom_range(3, 0) != 0 && f3 != 3'd7)
        addr = addr & ~64'(nbytes(f3) - 1);
      run_txn(we, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(3, 0), $urandom_range(3, 0));
      idle_gap($urandom_range(2, 0));
    end

    idle_gap(5);
    chk("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
    chk("ld_queue_drained", 64'(exp_ld_q.size()), 64'd0);
    chk("stall_queue_drained", 64'(exp_stall_q.size()), 64'd0);
    chk("lsu_err_pulses", 64'(seen_err), 64'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
